// File: rtl/ula_pkg.sv
// Shared types for the ULA sweep sequencer.
// Holds widths, FSM states and the result beat layout.
package ula_pkg;

  localparam int ULA_WIDTH = 6;
  localparam int ULA_SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    HOLD
  } ula_seq_state_t;

  typedef struct packed {
    logic [ULA_SEL_W-1:0] sel;
    logic [ULA_WIDTH-1:0] o;
    logic                 overflow;
    logic                 zero;
    logic                 last;
  } ula_result_t;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/ula_sweep_sequencer.sv
// Sweeps one operand pair through ALU opcodes OP_FIRST..OP_LAST
// and streams one captured result beat per opcode downstream.
module ula_sweep_sequencer
  import ula_pkg::*;
#(
  parameter int WIDTH    = ULA_WIDTH,
  parameter int SEL_W    = ULA_SEL_W,
  parameter int OP_FIRST = 0,
  parameter int OP_LAST  = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  output logic [WIDTH-1:0] o_alu_a,
  output logic [WIDTH-1:0] o_alu_b,
  output logic [SEL_W-1:0] o_alu_sel,
  output logic             o_alu_reset,
  input  logic [WIDTH-1:0] i_alu_o,
  input  logic             i_alu_overflow,
  input  logic             i_alu_zero,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [SEL_W-1:0] o_out_sel,
  output logic [WIDTH-1:0] o_out_o,
  output logic             o_out_overflow,
  output logic             o_out_zero,
  output logic             o_out_last,
  output logic             o_busy,
  output logic [7:0]       o_sweep_count
);

  // Result bundle is shared with the ALU wrapper, so widths are fixed.
  if (WIDTH != ULA_WIDTH || SEL_W != ULA_SEL_W ||
      OP_FIRST < 0 || OP_FIRST > OP_LAST ||
      OP_LAST > (2**SEL_W) - 1) begin : g_bad_params
    $error("ula_sweep_sequencer: illegal parameters");
  end

  localparam logic [SEL_W-1:0] LP_FIRST = SEL_W'(OP_FIRST);
  localparam logic [SEL_W-1:0] LP_LAST  = SEL_W'(OP_LAST);

  ula_seq_state_t   r_state;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [SEL_W-1:0] r_alu_sel;
  ula_result_t      r_res;
  logic             r_out_valid;
  logic [7:0]       r_count;

  // Sweep FSM: accept pair, settle ALU, capture, wait for downstream.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_in_valid) begin
            r_alu_a   <= i_in_a;
            r_alu_b   <= i_in_b;
            r_alu_sel <= LP_FIRST;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_res.sel      <= r_alu_sel;
          r_res.o        <= i_alu_o;
          r_res.overflow <= i_alu_overflow;
          r_res.zero     <= i_alu_zero;
          r_res.last     <= (r_alu_sel == LP_LAST);
          r_out_valid    <= 1'b1;
          r_state        <= HOLD;
        end
        HOLD: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            if (r_res.last) begin
              r_count <= sat_inc8(r_count);
              r_state <= IDLE;
            end else begin
              r_alu_sel <= r_alu_sel + 1'b1;
              r_state   <= ISSUE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_in_ready     = (r_state == IDLE);
  assign o_busy         = (r_state != IDLE);
  assign o_alu_a        = r_alu_a;
  assign o_alu_b        = r_alu_b;
  assign o_alu_sel      = r_alu_sel;
  assign o_alu_reset    = 1'b0;
  assign o_out_valid    = r_out_valid;
  assign o_out_sel      = r_res.sel;
  assign o_out_o        = r_res.o;
  assign o_out_overflow = r_res.overflow;
  assign o_out_zero     = r_res.zero;
  assign o_out_last     = r_res.last;
  assign o_sweep_count  = r_count;

endmodule

// File: tb/tb_ula_sweep_sequencer.sv
// Bench for ula_sweep_sequencer with a behavioural ALU stand-in.
// Reference: ALU rules, beat ordering and a saturating sweep tally.
module tb_ula_sweep_sequencer;
  import ula_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [5:0] in_a = '0;
  logic [5:0] in_b = '0;
  logic [5:0] alu_a, alu_b, alu_o;
  logic [3:0] alu_sel;
  logic       alu_reset, alu_ovf, alu_zero;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [3:0] out_sel;
  logic [5:0] out_o;
  logic       out_ovf, out_zero, out_last, busy;
  logic [7:0] sweep_count;

  logic       s_in_valid = 1'b0;
  logic       s_in_ready;
  logic [5:0] s_in_a = '0;
  logic [5:0] s_in_b = '0;
  logic [5:0] s_alu_a, s_alu_b, s_alu_o;
  logic [3:0] s_alu_sel;
  logic       s_alu_reset, s_alu_ovf, s_alu_zero;
  logic       s_out_valid;
  logic       s_out_ready = 1'b1;
  logic [3:0] s_out_sel;
  logic [5:0] s_out_o;
  logic       s_out_ovf, s_out_zero, s_out_last, s_busy;
  logic [7:0] s_sweep_count;

  int n_checks = 0;
  int n_fail = 0;
  int exp_count = 0;

  // Reference ALU: {overflow, zero, o[5:0]}
  function automatic logic [7:0] alu_ref(
    input logic [5:0] a,
    input logic [5:0] b,
    input logic [3:0] s
  );
    logic [5:0] r;
    logic       v;
    r = '0;
    v = 1'b0;
    case (s)
      4'd0: begin
        r = a + b;
        v = (a[5] == b[5]) && (r[5] != a[5]);
      end
      4'd1: begin
        r = a - b;
        v = (a[5] != b[5]) && (r[5] != a[5]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: begin
        r = a + 6'd1;
        v = (a == 6'h1F);
      end
      4'd7: begin
        r = a - 6'd1;
        v = (a == 6'h20);
      end
      default: r = b;
    endcase
    return {v, (r == 6'd0), r};
  endfunction

  assign {alu_ovf, alu_zero, alu_o} = alu_ref(alu_a, alu_b, alu_sel);
  assign {s_alu_ovf, s_alu_zero, s_alu_o} =
    alu_ref(s_alu_a, s_alu_b, s_alu_sel);

  ula_sweep_sequencer u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_valid     (in_valid),
    .o_in_ready     (in_ready),
    .i_in_a         (in_a),
    .i_in_b         (in_b),
    .o_alu_a        (alu_a),
    .o_alu_b        (alu_b),
    .o_alu_sel      (alu_sel),
    .o_alu_reset    (alu_reset),
    .i_alu_o        (alu_o),
    .i_alu_overflow (alu_ovf),
    .i_alu_zero     (alu_zero),
    .o_out_valid    (out_valid),
    .i_out_ready    (out_ready),
    .o_out_sel      (out_sel),
    .o_out_o        (out_o),
    .o_out_overflow (out_ovf),
    .o_out_zero     (out_zero),
    .o_out_last     (out_last),
    .o_busy         (busy),
    .o_sweep_count  (sweep_count)
  );

  ula_sweep_sequencer #(
    .OP_FIRST (15),
    .OP_LAST  (15)
  ) u_one (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_in_valid     (s_in_valid),
    .o_in_ready     (s_in_ready),
    .i_in_a         (s_in_a),
    .i_in_b         (s_in_b),
    .o_alu_a        (s_alu_a),
    .o_alu_b        (s_alu_b),
    .o_alu_sel      (s_alu_sel),
    .o_alu_reset    (s_alu_reset),
    .i_alu_o        (s_alu_o),
    .i_alu_overflow (s_alu_ovf),
    .i_alu_zero     (s_alu_zero),
    .o_out_valid    (s_out_valid),
    .i_out_ready    (s_out_ready),
    .o_out_sel      (s_out_sel),
    .o_out_o        (s_out_o),
    .o_out_overflow (s_out_ovf),
    .o_out_zero     (s_out_zero),
    .o_out_last     (s_out_last),
    .o_busy         (s_busy),
    .o_sweep_count  (s_sweep_count)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready_during: got %b exp 1", in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, busy, alu_reset} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b exp 1000",
               {in_ready, out_valid, busy, alu_reset});
    end
    n_checks++;
    if (sweep_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d exp 0", sweep_count);
    end
    n_checks++;
    if ({out_sel, out_o, out_last} !== 11'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %h exp 0",
               {out_sel, out_o, out_last});
    end
  endtask

  task automatic accept(
    input logic [5:0] a,
    input logic [5:0] b,
    input bit         keep
  );
    @(negedge clk);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: got %b exp 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  // Called at the negedge right after the accept edge.
  task automatic drain(
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  bit         rnd,
    input  bit         hold,
    output int         cyc
  );
    int          beats;
    logic [3:0]  es;
    bit          held;
    bit          rdy;
    logic [12:0] snap;
    logic [12:0] cur;
    logic [7:0]  r;
    es = 4'd0;
    beats = 0;
    held = 1'b0;
    snap = '0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 400) begin
      n_checks++;
      if (alu_a !== a || alu_b !== b) begin
        n_fail++;
        $display("FAIL alu_operands: got %h/%h exp %h/%h",
                 alu_a, alu_b, a, b);
      end
      if (hold) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_in_ready: got %b exp 0", in_ready);
        end
      end
      if (cyc < 2) begin
        n_checks++;
        if (out_valid !== (cyc == 1)) begin
          n_fail++;
          $display("FAIL latency_c%0d: got %b exp %b",
                   cyc, out_valid, (cyc == 1));
        end
      end
      cur = {out_sel, out_o, out_ovf, out_zero, out_last};
      if (out_valid === 1'b1) begin
        if (held) begin
          n_checks++;
          if (cur !== snap) begin
            n_fail++;
            $display("FAIL stall_stable: got %h exp %h", cur, snap);
          end
        end
        r = alu_ref(a, b, es);
        n_checks++;
        if (cur !== {es, r[5:0], r[7], r[6], (es == 4'd7)}) begin
          n_fail++;
          $display("FAIL beat_sel%0d: got %h exp %h", es, cur,
                   {es, r[5:0], r[7], r[6], (es == 4'd7)});
        end
        snap = cur;
      end
      rdy = rnd ? ($urandom_range(0, 1) != 0) : 1'b1;
      out_ready = rdy;
      if (out_valid === 1'b1 && rdy) begin
        beats++;
        es = es + 4'd1;
        held = 1'b0;
      end else begin
        held = (out_valid === 1'b1);
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
    n_checks++;
    if (busy !== 1'b0 || beats != 8) begin
      n_fail++;
      $display("FAIL sweep_beats: got %0d busy %b exp 8 busy 0",
               beats, busy);
    end
    if (beats == 8 && exp_count < 255) exp_count++;
    n_checks++;
    if (sweep_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL sweep_count: got %0d exp %0d",
               sweep_count, exp_count);
    end
  endtask

  task automatic test_abort();
    int  n;
    bit  found;
    bit  seen;
    found = 1'b0;
    seen = 1'b0;
    accept(6'd5, 6'd3, 1'b0);
    out_ready = 1'b1;
    for (n = 0; n < 40; n++) begin
      if (out_valid === 1'b1 && out_sel === 4'd3) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL abort_reach: got none exp sel 3 beat");
    end
    out_ready = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL abort_state: got %b exp 001",
               {out_valid, busy, in_ready});
    end
    n_checks++;
    if (sweep_count !== 8'(exp_count)) begin
      n_fail++;
      $display("FAIL abort_count: got %0d exp %0d",
               sweep_count, exp_count);
    end
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL abort_no_beat: got beat exp none");
    end
  endtask

  task automatic test_basic();
    int cyc;
    accept(6'd5, 6'd3, 1'b0);
    drain(6'd5, 6'd3, 1'b0, 1'b0, cyc);
    n_checks++;
    if (cyc != 16) begin
      n_fail++;
      $display("FAIL sweep_cycles: got %0d exp 16", cyc);
    end
  endtask

  task automatic test_stall();
    int cyc;
    accept(6'd63, 6'd1, 1'b0);
    drain(6'd63, 6'd1, 1'b1, 1'b0, cyc);
    accept(6'd32, 6'd32, 1'b0);
    drain(6'd32, 6'd32, 1'b1, 1'b0, cyc);
  endtask

  task automatic test_hold_valid();
    int cyc;
    accept(6'd5, 6'd7, 1'b1);
    in_a = 6'd9;
    in_b = 6'd2;
    drain(6'd5, 6'd7, 1'b0, 1'b1, cyc);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_ready: got %b exp 1", in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (alu_a !== 6'd9 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL held_accept: got a=%0d busy=%b exp 9 1",
               alu_a, busy);
    end
    drain(6'd9, 6'd2, 1'b0, 1'b0, cyc);
  endtask

  task automatic test_back_to_back();
    int         cyc;
    logic [5:0] a;
    logic [5:0] b;
    for (int i = 0; i < 256; i++) begin
      a = 6'($urandom);
      b = 6'($urandom);
      accept(a, b, 1'b0);
      drain(a, b, 1'b0, 1'b0, cyc);
    end
    n_checks++;
    if (sweep_count !== 8'd255) begin
      n_fail++;
      $display("FAIL count_saturate: got %0d exp 255", sweep_count);
    end
  endtask

  task automatic test_single_op();
    int         beats;
    int         cyc;
    logic [7:0] r;
    beats = 0;
    cyc = 0;
    r = alu_ref(6'd12, 6'd34, 4'd15);
    @(negedge clk);
    s_in_a = 6'd12;
    s_in_b = 6'd34;
    s_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_in_valid = 1'b0;
    while (s_busy === 1'b1 && cyc < 20) begin
      if (s_out_valid === 1'b1) begin
        beats++;
        n_checks++;
        if ({s_out_sel, s_out_last, s_out_o} !== {4'd15, 1'b1, r[5:0]})
        begin
          n_fail++;
          $display("FAIL single_beat: got %h exp %h",
                   {s_out_sel, s_out_last, s_out_o},
                   {4'd15, 1'b1, r[5:0]});
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (beats != 1 || cyc != 2 || s_sweep_count !== 8'd1) begin
      n_fail++;
      $display("FAIL single_sweep: got %0d/%0d/%0d exp 1/2/1",
               beats, cyc, s_sweep_count);
    end
  endtask

  initial begin
    test_reset();
    test_abort();
    test_basic();
    test_stall();
    test_hold_valid();
    test_single_op();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
